// File: rtl/pmod_dac_writer_pkg.sv
// Shared constants, frame helper and FSM state encoding for the Pmod DAC writer.
package pmod_dac_pkg;

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned DATA_W  = 12;

  localparam logic [1:0] PD_NORMAL = 2'b00;
  localparam logic [1:0] PD_1K     = 2'b01;
  localparam logic [1:0] PD_100K   = 2'b10;
  localparam logic [1:0] PD_HIZ    = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_SETUP = 4'b0010,
    ST_SHIFT = 4'b0100,
    ST_GAP   = 4'b1000
  } state_e;

  function automatic logic [FRAME_W-1:0] make_frame(input logic [1:0]        pd,
                                                    input logic [DATA_W-1:0] code);
    return {2'b00, pd, code};
  endfunction

endpackage

// File: rtl/pmod_dac_writer_if.sv
// Sample-write handshake between game logic and the DAC writer.
// DAC_DUAL_CHANNEL_EN adds the second-channel sample wr_data_b.
interface pmod_dac_writer_if;
  import pmod_dac_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        wr_pd;
  logic              done;
`ifdef DAC_DUAL_CHANNEL_EN
  logic [DATA_W-1:0] wr_data_b;

  modport master (output wr_valid, wr_data, wr_data_b, wr_pd, input wr_ready, done);
  modport slave  (input wr_valid, wr_data, wr_data_b, wr_pd, output wr_ready, done);
`else
  modport master (output wr_valid, wr_data, wr_pd, input wr_ready, done);
  modport slave  (input wr_valid, wr_data, wr_pd, output wr_ready, done);
`endif
endinterface

// File: rtl/pmod_dac_writer_sclk_tick.sv
// Half-period timer: strobes tick_o every CLK_DIV enabled cycles, restarts when disabled.
module dac_sclk_tick #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic tick_o
);
  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = '0;
    if (en_i && !tick_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/pmod_dac_writer.sv
// SPI-style frame transmitter for a DAC121S101-class Pmod.
// DAC_DUAL_CHANNEL_EN adds a lockstep second data line dac_din_b.
module pmod_dac_writer
  import pmod_dac_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned GAP_HALVES = 2
) (
  input  logic                clk,
  input  logic                reset,
  pmod_dac_writer_if.slave    wr,
  output logic                dac_sync_n,
  output logic                dac_sclk,
  output logic                dac_din
`ifdef DAC_DUAL_CHANNEL_EN
  ,
  output logic                dac_din_b
`endif
);
  localparam int unsigned GW = (GAP_HALVES > 1) ? $clog2(GAP_HALVES) : 1;

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic               sync_q, sync_d;
  logic               sclk_q, sclk_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic [4:0]         fall_q, fall_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic               tick;
`ifdef DAC_DUAL_CHANNEL_EN
  logic [FRAME_W-1:0] sr_b_q, sr_b_d;
`endif

  dac_sclk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .en_i   (state_q != ST_IDLE),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    sync_d  = sync_q;
    sclk_d  = sclk_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    fall_d  = fall_q;
    gap_d   = gap_q;
`ifdef DAC_DUAL_CHANNEL_EN
    sr_b_d  = sr_b_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (wr.wr_valid && ready_q) begin
          state_d = ST_SETUP;
          sr_d    = make_frame(wr.wr_pd, wr.wr_data);
`ifdef DAC_DUAL_CHANNEL_EN
          sr_b_d  = make_frame(wr.wr_pd, wr.wr_data_b);
`endif
          sync_d  = 1'b0;
          ready_d = 1'b0;
          fall_d  = '0;
          gap_d   = '0;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_d = ST_SHIFT;
          sclk_d  = 1'b0;
          fall_d  = 5'd1;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          if (sclk_q) begin
            sclk_d = 1'b0;
            fall_d = fall_q + 5'd1;
          end else begin
            sclk_d = 1'b1;
            // Clearing the shifter on the final rise also returns dac_din to 0.
            if (fall_q == 5'd16) begin
              state_d = ST_GAP;
              sync_d  = 1'b1;
              sr_d    = '0;
`ifdef DAC_DUAL_CHANNEL_EN
              sr_b_d  = '0;
`endif
            end else begin
              sr_d    = {sr_q[FRAME_W-2:0], 1'b0};
`ifdef DAC_DUAL_CHANNEL_EN
              sr_b_d  = {sr_b_q[FRAME_W-2:0], 1'b0};
`endif
            end
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (gap_q == GW'(GAP_HALVES - 1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            ready_d = 1'b1;
            gap_d   = '0;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      sync_q  <= 1'b1;
      sclk_q  <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      fall_q  <= '0;
      gap_q   <= '0;
`ifdef DAC_DUAL_CHANNEL_EN
      sr_b_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      sync_q  <= sync_d;
      sclk_q  <= sclk_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      fall_q  <= fall_d;
      gap_q   <= gap_d;
`ifdef DAC_DUAL_CHANNEL_EN
      sr_b_q  <= sr_b_d;
`endif
    end
  end

  assign wr.wr_ready = ready_q;
  assign wr.done     = done_q;
  assign dac_sync_n  = sync_q;
  assign dac_sclk    = sclk_q;
  assign dac_din     = sr_q[FRAME_W-1];
`ifdef DAC_DUAL_CHANNEL_EN
  assign dac_din_b   = sr_b_q[FRAME_W-1];
`endif
endmodule

// File: tb/tb_pmod_dac_writer.sv
// Randomized bench for pmod_dac_writer against a cycle-offset timing model.
module tb_pmod_dac_writer;
  localparam int unsigned D      = 2;
  localparam int unsigned G      = 2;
  localparam int unsigned SYNC_T = 32 * D;
  localparam int unsigned DONE_T = (32 + G) * D;

  logic clk = 1'b0;
  logic reset;
  logic dac_sync_n, dac_sclk, dac_din;
`ifdef DAC_DUAL_CHANNEL_EN
  logic dac_din_b;
`endif

  always #5 clk = ~clk;

  pmod_dac_writer_if wr_if ();

  pmod_dac_writer #(.CLK_DIV(D), .GAP_HALVES(G)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr         (wr_if.slave),
    .dac_sync_n (dac_sync_n),
    .dac_sclk   (dac_sclk),
    .dac_din    (dac_din)
`ifdef DAC_DUAL_CHANNEL_EN
    ,
    .dac_din_b  (dac_din_b)
`endif
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Model: a frame is just "cycles since accept" plus the captured words.
  bit          m_active = 1'b0;
  int unsigned m_t = 0;
  logic [15:0] m_frame = '0;
  logic [15:0] m_frame_b = '0;
  bit          last_acc;

  function automatic bit m_ready();
    return !m_active || (m_t == DONE_T);
  endfunction

  logic        prev_sclk = 1'b1;
  logic        prev_sync = 1'b1;
  logic [15:0] dec = '0;
  logic [15:0] dec_b = '0;
  int unsigned nbits = 0;

  task automatic check_outputs();
    logic e_sync, e_sclk, e_din, e_din_b, e_done, e_ready;
    int unsigned idx;
    e_sync = 1'b1; e_sclk = 1'b1; e_din = 1'b0; e_din_b = 1'b0;
    e_done = 1'b0; e_ready = 1'b1;
    if (m_active) begin
      e_ready = (m_t == DONE_T);
      e_done  = (m_t == DONE_T);
      if (m_t < SYNC_T) begin
        idx     = 15 - m_t / (2 * D);
        e_sync  = 1'b0;
        e_sclk  = ((m_t / D) % 2 == 0);
        e_din   = m_frame[idx];
        e_din_b = m_frame_b[idx];
      end
    end
    chk("sync_n", dac_sync_n, e_sync);
    chk("sclk", dac_sclk, e_sclk);
    chk("din", dac_din, e_din);
    chk("done", wr_if.done, e_done);
    chk("ready", wr_if.wr_ready, e_ready);
`ifdef DAC_DUAL_CHANNEL_EN
    chk("din_b", dac_din_b, e_din_b);
`endif
    // Independent decode of what the DAC would latch on falling SCLK edges.
    if (!dac_sync_n && prev_sync) begin
      nbits = 0; dec = '0; dec_b = '0;
    end
    if (!dac_sync_n && prev_sclk && !dac_sclk) begin
      dec = {dec[14:0], dac_din};
`ifdef DAC_DUAL_CHANNEL_EN
      dec_b = {dec_b[14:0], dac_din_b};
`endif
      nbits++;
    end
    if (dac_sync_n && !prev_sync && nbits == 16) begin
      chk("frame", dec, m_frame);
`ifdef DAC_DUAL_CHANNEL_EN
      chk("frame_b", dec_b, m_frame_b);
`endif
    end
    prev_sclk = dac_sclk;
    prev_sync = dac_sync_n;
  endtask

  task automatic cycle(input logic rst, input logic v, input logic [11:0] data, input logic [1:0] pd);
    reset          = rst;
    wr_if.wr_valid = v;
    wr_if.wr_data  = data;
    wr_if.wr_pd    = pd;
    last_acc       = 1'b0;
    if (rst) begin
      m_active = 1'b0;
    end else if (v && m_ready()) begin
      m_active = 1'b1;
      m_t      = 0;
      m_frame  = {2'b00, pd, data};
`ifdef DAC_DUAL_CHANNEL_EN
      m_frame_b = {2'b00, pd, wr_if.wr_data_b};
`endif
      last_acc = 1'b1;
    end else if (m_active) begin
      if (m_t == DONE_T) m_active = 1'b0;
      else               m_t++;
    end
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    reset          = 1'b1;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = '0;
    wr_if.wr_pd    = '0;
`ifdef DAC_DUAL_CHANNEL_EN
    wr_if.wr_data_b = '0;
`endif
    repeat (3)  cycle(1'b1, 1'b0, 12'h000, 2'b00);
    repeat (10) cycle(1'b0, 1'b0, 12'h000, 2'b00);

    cycle(1'b0, 1'b1, 12'hA5C, 2'b00);
    repeat (75) cycle(1'b0, 1'b0, 12'h000, 2'b00);

    // Back-to-back with valid held high.
    cycle(1'b0, 1'b1, 12'hFFF, 2'b00);
    last_acc = 1'b0;
    for (int i = 0; i < 200 && !last_acc; i++) cycle(1'b0, 1'b1, 12'h000, 2'b00);
    chk("b2b_accept", {31'd0, last_acc}, 32'd1);
    chk("b2b_spacing", m_t, 32'd0);
    repeat (75) cycle(1'b0, 1'b0, 12'h000, 2'b00);

    // A request mid-frame must be ignored.
    cycle(1'b0, 1'b1, 12'h5A5, 2'b01);
    repeat (20) cycle(1'b0, 1'b0, 12'h000, 2'b00);
    cycle(1'b0, 1'b1, 12'h123, 2'b00);
    repeat (60) cycle(1'b0, 1'b0, 12'h000, 2'b00);

    // Reset just after the 7th falling SCLK edge, then a clean frame.
    cycle(1'b0, 1'b1, 12'h3C3, 2'b10);
    for (int i = 0; i < 100 && m_active && m_t < 13 * D + 1; i++)
      cycle(1'b0, 1'b0, 12'h000, 2'b00);
    cycle(1'b1, 1'b0, 12'h000, 2'b00);
    cycle(1'b0, 1'b1, 12'h800, 2'b00);
    repeat (75) cycle(1'b0, 1'b0, 12'h000, 2'b00);

`ifdef DAC_DUAL_CHANNEL_EN
    wr_if.wr_data_b = 12'hFFE;
    cycle(1'b0, 1'b1, 12'h001, 2'b11);
    repeat (75) cycle(1'b0, 1'b0, 12'h000, 2'b00);
`endif

    for (int i = 0; i < 3000; i++) begin
`ifdef DAC_DUAL_CHANNEL_EN
      wr_if.wr_data_b = 12'($urandom);
`endif
      cycle($urandom_range(0, 399) == 0, $urandom_range(0, 3) == 0,
            12'($urandom), 2'($urandom));
    end
    repeat (80) cycle(1'b0, 1'b0, 12'h000, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
